uart_tx_param: RTL

Parametrised UART transmitter that replaces the fixed 8-bit transmitter. Data width, parity mode, stop-bit count and baud divisor are configurable. It takes bytes (or words) over a valid/ready handshake into a one-entry holding register, then serialises them LSB-first. It runs entirely in the clk1 domain and uses a baud clock-enable, not a derived clock. It sits between the host-side data path and the tx pad.

---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_baud_en.sv | 33 +++
 rtl/uart_tx_param.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity modes and the parity helper.
// The BREAK state exists only when UART_TX_BREAK_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
`ifdef UART_TX_BREAK_EN
    , BREAK = 3'd6
`endif
  } state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } par_mode_e;

  // Only the low 'width' bits of data contribute; mode 2'b11 behaves as none.
  function automatic logic parity_bit(input logic [1:0] mode,
                                      input logic [8:0] data,
                                      input int unsigned width);
    logic x;
    x = 1'b0;
    for (int unsigned i = 0; i < 9; i++) begin
      if (i < width) x = x ^ data[i];
    end
    case (mode)
      PAR_EVEN: return x;
      PAR_ODD:  return ~x;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_en.sv
// Baud-rate divisor counter: runs 0..div-1 and strobes bit_end_o on the last cycle of
// each bit. clr_i realigns the count to zero; a divisor of 0 behaves as 1.
module uart_baud_en #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             bit_end_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_eff;

  always_comb begin
    div_eff = div_i;
    if (div_i == '0) div_eff = DIV_W'(1);
  end

  assign bit_end_o = (cnt_q == div_eff - DIV_W'(1));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clr_i || bit_end_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a one-entry holding register and shadowed config.
// Define UART_TX_BREAK_EN to add the send_break input and the BREAK state.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned RST_DIV = 434
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done
`ifdef UART_TX_BREAK_EN
  ,
  input  logic              send_break
`endif
);

  localparam int unsigned IDX_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_e            state_q;
  logic [DATA_W-1:0] hold_q;
  logic              hold_full_q;
  logic [DATA_W-1:0] shift_q;
  logic [IDX_W-1:0]  idx_q;
  logic [1:0]        par_q;
  logic              par_bit_q;
  logic              stop2_q;
  logic [DIV_W-1:0]  div_q;
  logic              tx_q;

  logic       bit_end;
  logic       final_stop;
  logic       accept;
  logic       launch;
  logic       par_en;
  logic       baud_clr;
  logic       par_calc;
  logic [8:0] data_ext;

  always_comb begin
    data_ext = '0;
    data_ext[DATA_W-1:0] = hold_q;
    par_calc = parity_bit(cfg_parity, data_ext, DATA_W);
  end

  assign par_en     = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
  assign final_stop = (state_q == STOP2) || ((state_q == STOP1) && !stop2_q);
  assign accept     = tx_valid && tx_ready;
  // A waiting word launches from IDLE or directly off the final stop bit (no gap).
  assign launch     = hold_full_q && ((state_q == IDLE) || (final_stop && bit_end));

`ifdef UART_TX_BREAK_EN
  localparam logic [IDX_W-1:0] BRK_LAST = IDX_W'(DATA_W + 3);
  logic brk_start;
  assign brk_start = (state_q == IDLE) && !hold_full_q && send_break;
  assign baud_clr  = launch || brk_start;
  assign tx_ready  = !hold_full_q && (state_q != BREAK);
`else
  assign baud_clr  = launch;
  assign tx_ready  = !hold_full_q;
`endif

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE);
  assign tx_done = final_stop && bit_end;

  uart_baud_en #(
    .DIV_W(DIV_W)
  ) u_baud (
    .clk_i    (clk1),
    .rst_n_i  (rst_n),
    .clr_i    (baud_clr),
    .div_i    (div_q),
    .bit_end_o(bit_end)
  );

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      idx_q       <= '0;
      par_q       <= '0;
      par_bit_q   <= 1'b0;
      stop2_q     <= 1'b0;
      div_q       <= DIV_W'(RST_DIV);
      tx_q        <= 1'b1;
    end else begin
      if (accept) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end else if (launch) begin
        hold_full_q <= 1'b0;
      end

      if (launch) begin
        state_q   <= START;
        shift_q   <= hold_q;
        idx_q     <= '0;
        par_q     <= cfg_parity;
        par_bit_q <= par_calc;
        stop2_q   <= cfg_stop2;
        div_q     <= cfg_div;
        tx_q      <= 1'b0;
      end
`ifdef UART_TX_BREAK_EN
      else if (brk_start) begin
        state_q <= BREAK;
        idx_q   <= '0;
        div_q   <= cfg_div;
        tx_q    <= 1'b0;
      end
`endif
      else if (bit_end) begin
        case (state_q)
          IDLE: ;
          START: begin
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            idx_q   <= '0;
            state_q <= DATA;
          end
          DATA: begin
            if (idx_q == LAST_IDX) begin
              idx_q <= '0;
              if (par_en) begin
                state_q <= PARITY;
                tx_q    <= par_bit_q;
              end else begin
                state_q <= STOP1;
                tx_q    <= 1'b1;
              end
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
              idx_q   <= idx_q + IDX_W'(1);
            end
          end
          PARITY: begin
            state_q <= STOP1;
            tx_q    <= 1'b1;
          end
          STOP1: state_q <= stop2_q ? STOP2 : IDLE;
          STOP2: state_q <= IDLE;
`ifdef UART_TX_BREAK_EN
          // DATA_W+3 bit times low, then one bit time high before IDLE.
          BREAK: begin
            if (idx_q == BRK_LAST) begin
              state_q <= IDLE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
              if (idx_q == BRK_LAST - IDX_W'(1)) tx_q <= 1'b1;
            end
          end
`endif
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
